prog_mem: RTL and testbench

- Parametrised, loadable program memory replacing the hard-coded asynchronous instruction ROM.
- A byte-serial loader fills the array at boot. The CPU fetch port then reads words with registered 1-cycle latency.
- Range and alignment are checked on every fetch. A faulting fetch returns NOP (addi x0,x0,0 = 32'h00000013).
- Sits between the boot/UART loader and the RISC-V fetch stage.

---
 rtl/prog_mem_if.sv | 35 +++
 rtl/prog_mem.sv | 167 ++++++++++++++++
 tb/tb_prog_mem.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_if
// Description : Loader and fetch bus bundle for the loadable program memory.
//               master = boot loader / CPU fetch side, slave = prog_mem.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_mem_if #(
  parameter int WIDTH      = 32,
  parameter int LOAD_WIDTH = 8
);
  logic                  load_start;
  logic                  load_valid;
  logic [LOAD_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  loaded;
  logic                  overflow;
  logic                  fetch_req;
  logic [WIDTH-1:0]      address;
  logic [WIDTH-1:0]      rdata;
  logic                  rvalid;
  logic                  fault;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_req, address,
    input  load_ready, loaded, overflow, rdata, rvalid, fault
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_req, address,
    output load_ready, loaded, overflow, rdata, rvalid, fault
  );
endinterface
`default_nettype wire

// File: rtl/prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem
// Description : Byte-serial loadable program memory with a registered,
//               range/alignment-checked instruction fetch port.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2048,
  parameter int LOAD_WIDTH = 8
) (
  input  wire logic  clock,
  input  wire logic  nreset,
  prog_mem_if.slave  bus
);

  localparam int BEATS = WIDTH / LOAD_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = AW + 1;

  localparam logic [WIDTH-1:0] C_NOP       = WIDTH'(32'h0000_0013);
  localparam logic [CW-1:0]    C_FULL      = CW'(DEPTH);
  localparam logic [BW-1:0]    C_LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Source of the fetch data output, held between fetches.
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_NOP  = 2'd2
  } sel_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  // Word count doubles as the program length: both clear on load entry and
  // advance together on every word write (padded last word included).
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             rvalid_q, rvalid_d;
  logic             fault_q, fault_d;
  sel_t             sel_q, sel_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] mem_rd_q;

  logic             w_beat_acc;
  logic             w_fetch_acc;
  logic             w_fetch_fault;
  logic [AW-1:0]    w_fetch_idx;
  logic [WIDTH-1:0] w_word_next;
  logic             w_mem_we;

  assign w_beat_acc    = (state_q == ST_LOAD) && bus.load_valid && !bus.load_start;
  assign w_fetch_acc   = (state_q == ST_RUN) && bus.fetch_req && !bus.load_start;
  assign w_fetch_idx   = bus.address[AW+1:2];
  assign w_fetch_fault = (bus.address[1:0] != 2'b00)
                      || ((bus.address >> (AW + 2)) != '0)
                      || ({1'b0, w_fetch_idx} >= wcnt_q);

  // Next-state, load assembly and fetch bookkeeping.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wcnt_d      = wcnt_q;
    ovf_d       = ovf_q;
    shift_d     = shift_q;
    w_mem_we    = 1'b0;
    w_word_next = shift_q;

    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == BW'(k)) begin
        w_word_next[k*LOAD_WIDTH +: LOAD_WIDTH] = bus.load_data;
      end
    end

    if (bus.load_start) begin
      state_d = ST_LOAD;
      beat_d  = '0;
      wcnt_d  = '0;
      ovf_d   = 1'b0;
      shift_d = '0;
    end else if (w_beat_acc) begin
      if (wcnt_q == C_FULL) begin
        ovf_d = 1'b1;
      end else if ((beat_q == C_LAST_BEAT) || bus.load_last) begin
        // Shift register is cleared after each word, so a short last word
        // arrives here already zero-padded in its upper beats.
        w_mem_we = 1'b1;
        wcnt_d   = wcnt_q + CW'(1);
        beat_d   = '0;
        shift_d  = '0;
      end else begin
        beat_d  = beat_q + BW'(1);
        shift_d = w_word_next;
      end
      if (bus.load_last) begin
        state_d = ST_RUN;
      end
    end

    rvalid_d = w_fetch_acc;
    fault_d  = w_fetch_acc && w_fetch_fault;
    sel_d    = sel_q;
    if (w_fetch_acc) begin
      sel_d = w_fetch_fault ? SEL_NOP : SEL_RAM;
    end
  end

  // Control and status registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      wcnt_q   <= '0;
      ovf_q    <= 1'b0;
      shift_q  <= '0;
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      sel_q    <= SEL_ZERO;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wcnt_q   <= wcnt_d;
      ovf_q    <= ovf_d;
      shift_q  <= shift_d;
      rvalid_q <= rvalid_d;
      fault_q  <= fault_d;
      sel_q    <= sel_d;
    end
  end

  // Single-write, single-read synchronous RAM with no reset, for block RAM.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      mem[wcnt_q[AW-1:0]] <= w_word_next;
    end
    if (w_fetch_acc) begin
      mem_rd_q <= mem[w_fetch_idx];
    end
  end

  // Output data mux: zero after reset, NOP for a faulted fetch, else RAM word.
  always_comb begin
    bus.rdata = '0;
    case (sel_q)
      SEL_RAM: bus.rdata = mem_rd_q;
      SEL_NOP: bus.rdata = C_NOP;
      default: bus.rdata = '0;
    endcase
  end

  assign bus.rvalid     = rvalid_q;
  assign bus.fault      = fault_q;
  assign bus.load_ready = (state_q == ST_LOAD);
  assign bus.loaded     = (state_q == ST_RUN);
  assign bus.overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_prog_mem
// Description : Self-checking bench for prog_mem: DEPTH=2048 and DEPTH=4
//               instances, byte-image reference model, directed + random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_mem;

  logic clock = 1'b0;
  logic nreset;
  always #5 clock = ~clock;

  prog_mem_if #(.WIDTH(32), .LOAD_WIDTH(8)) if0 ();
  prog_mem_if #(.WIDTH(32), .LOAD_WIDTH(8)) if1 ();

  prog_mem #(.WIDTH(32), .DEPTH(2048), .LOAD_WIDTH(8)) u_dut0 (
    .clock (clock), .nreset(nreset), .bus(if0));
  prog_mem #(.WIDTH(32), .DEPTH(4), .LOAD_WIDTH(8)) u_dut1 (
    .clock (clock), .nreset(nreset), .bus(if1));

  logic        ls[2], lv[2], llast[2], fr[2];
  logic [7:0]  ldat[2];
  logic [31:0] addr[2];
  logic        o_ready[2], o_loaded[2], o_ovf[2], o_rvalid[2], o_fault[2];
  logic [31:0] o_rdata[2];

  assign if0.load_start = ls[0];    assign if1.load_start = ls[1];
  assign if0.load_valid = lv[0];    assign if1.load_valid = lv[1];
  assign if0.load_data  = ldat[0];  assign if1.load_data  = ldat[1];
  assign if0.load_last  = llast[0]; assign if1.load_last  = llast[1];
  assign if0.fetch_req  = fr[0];    assign if1.fetch_req  = fr[1];
  assign if0.address    = addr[0];  assign if1.address    = addr[1];
  assign o_ready[0]  = if0.load_ready; assign o_ready[1]  = if1.load_ready;
  assign o_loaded[0] = if0.loaded;     assign o_loaded[1] = if1.loaded;
  assign o_ovf[0]    = if0.overflow;   assign o_ovf[1]    = if1.overflow;
  assign o_rvalid[0] = if0.rvalid;     assign o_rvalid[1] = if1.rvalid;
  assign o_fault[0]  = if0.fault;      assign o_fault[1]  = if1.fault;
  assign o_rdata[0]  = if0.rdata;      assign o_rdata[1]  = if1.rdata;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model: the raw byte stream of the last load per instance.
  logic [7:0]  img [2][0:8191];
  int          nbytes[2];
  int          depth_of[2];
  logic [7:0]  stage[$];
  logic [31:0] fq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int model_len(input int d);
    int w;
    w = (nbytes[d] + 3) / 4;
    return (w > depth_of[d]) ? depth_of[d] : w;
  endfunction

  function automatic void model_fetch(input int d, input logic [31:0] a,
                                      output logic [31:0] w, output logic f);
    int idx;
    w = 32'h0000_0013;
    f = 1'b1;
    if (a[1:0] == 2'b00 && a < 32'(model_len(d) * 4)) begin
      f = 1'b0;
      for (int k = 0; k < 4; k++) begin
        idx = int'(a) + k;
        w[8*k +: 8] = (idx < nbytes[d]) ? img[d][idx] : 8'h00;
      end
    end
  endfunction

  // Stream the staged bytes, optionally preceded by a load_start pulse.
  task automatic do_load(input int d, input bit gaps, input bit start);
    if (start) begin
      ls[d] = 1'b1;
      tick();
      ls[d] = 1'b0;
      check("load_ready_after_start", {31'b0, o_ready[d]}, 32'd1);
      check("overflow_cleared", {31'b0, o_ovf[d]}, 32'd0);
    end
    for (int i = 0; i < stage.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        lv[d] = 1'b0;
        tick();
      end
      lv[d]    = 1'b1;
      ldat[d]  = stage[i];
      llast[d] = (i == stage.size() - 1);
      tick();
    end
    lv[d]    = 1'b0;
    llast[d] = 1'b0;
    nbytes[d] = stage.size();
    for (int i = 0; i < stage.size(); i++) img[d][i] = stage[i];
    check("loaded", {31'b0, o_loaded[d]}, 32'd1);
    check("overflow", {31'b0, o_ovf[d]}, {31'b0, (nbytes[d] > depth_of[d] * 4)});
  endtask

  // Back-to-back fetches of every address in fq, then a hold check.
  task automatic fetch_burst(input int d);
    logic [31:0] ew;
    logic        ef;
    ew = 32'h0;
    for (int i = 0; i < fq.size(); i++) begin
      fr[d]   = 1'b1;
      addr[d] = fq[i];
      tick();
      model_fetch(d, fq[i], ew, ef);
      check($sformatf("rvalid@%h", fq[i]), {31'b0, o_rvalid[d]}, 32'd1);
      check($sformatf("rdata@%h", fq[i]), o_rdata[d], ew);
      check($sformatf("fault@%h", fq[i]), {31'b0, o_fault[d]}, {31'b0, ef});
    end
    fr[d] = 1'b0;
    tick();
    check("rvalid_idle", {31'b0, o_rvalid[d]}, 32'd0);
    check("fault_idle", {31'b0, o_fault[d]}, 32'd0);
    check("rdata_hold", o_rdata[d], ew);
  endtask

  initial begin
    int n, len;
    for (int d = 0; d < 2; d++) begin
      ls[d] = 0; lv[d] = 0; llast[d] = 0; fr[d] = 0; ldat[d] = 0; addr[d] = 0;
      nbytes[d] = 0;
    end
    depth_of[0] = 2048;
    depth_of[1] = 4;

    // Reset state
    nreset = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_load_ready", {31'b0, o_ready[d]}, 32'd0);
      check("rst_loaded", {31'b0, o_loaded[d]}, 32'd0);
      check("rst_overflow", {31'b0, o_ovf[d]}, 32'd0);
      check("rst_rvalid", {31'b0, o_rvalid[d]}, 32'd0);
      check("rst_fault", {31'b0, o_fault[d]}, 32'd0);
      check("rst_rdata", o_rdata[d], 32'd0);
    end
    nreset = 1'b1;

    // Fetch while IDLE: never valid
    fr[0] = 1'b1;
    addr[0] = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_rvalid", {31'b0, o_rvalid[0]}, 32'd0);
    end
    fr[0] = 1'b0;

    // Two-instruction program, back-to-back fetch
    stage = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    do_load(0, 1'b0, 1'b1);
    fq = '{32'h0, 32'h4};
    fetch_burst(0);
    check("t1_word1_const", o_rdata[0], 32'h00A0_0113);
    fq = '{32'h8};
    fetch_burst(0);
    check("t1_range_nop", o_rdata[0], 32'h0000_0013);
    fq = '{32'h2};
    fetch_burst(0);

    // Short last word is zero-padded
    stage = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_load(0, 1'b0, 1'b1);
    fq = '{32'h4, 32'h0, 32'h8};
    fetch_burst(0);
    fq = '{32'h4};
    fetch_burst(0);
    check("t2_pad_const", o_rdata[0], 32'h0000_0055);

    // Random programs and random fetch mixes
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 40);
      stage.delete();
      for (int i = 0; i < n; i++) stage.push_back(8'($urandom));
      do_load(0, 1'b1, 1'b1);
      len = model_len(0);
      fq.delete();
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 3))
          0: fq.push_back(32'($urandom_range(0, len - 1)) << 2);
          1: fq.push_back(32'($urandom_range(0, len + 2)) << 2);
          2: fq.push_back((32'($urandom_range(0, len)) << 2) | 32'($urandom_range(1, 3)));
          default: fq.push_back(32'h8000_0000 | (32'($urandom_range(0, len - 1)) << 2));
        endcase
      end
      fetch_burst(0);
    end

    // DEPTH=4 overflow: 20 beats, words 0..3 kept, last still honoured
    stage.delete();
    for (int i = 0; i < 20; i++) stage.push_back(8'($urandom));
    do_load(1, 1'b1, 1'b1);
    fq = '{32'hC, 32'h0, 32'h4, 32'h8, 32'h10, 32'h0000_4000};
    fetch_burst(1);

    // load_start together with load_valid drops that beat and restarts
    ls[0] = 1'b1;
    tick();
    ls[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lv[0] = 1'b1;
      ldat[0] = 8'($urandom);
      tick();
    end
    ls[0] = 1'b1;
    lv[0] = 1'b1;
    ldat[0] = 8'hAA;
    tick();
    ls[0] = 1'b0;
    lv[0] = 1'b0;
    check("restart_load_ready", {31'b0, o_ready[0]}, 32'd1);
    stage = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    do_load(0, 1'b0, 1'b0);
    fq = '{32'h0, 32'h4, 32'h8};
    fetch_burst(0);

    // load_start with fetch_req in RUN: fetch dropped, load wins
    ls[0] = 1'b1;
    fr[0] = 1'b1;
    addr[0] = 32'h0;
    tick();
    ls[0] = 1'b0;
    fr[0] = 1'b0;
    check("ldstart_fetch_rvalid", {31'b0, o_rvalid[0]}, 32'd0);
    check("ldstart_fetch_ready", {31'b0, o_ready[0]}, 32'd1);
    stage = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_load(0, 1'b0, 1'b0);
    fq = '{32'h0, 32'h4};
    fetch_burst(0);

    // Reset in the middle of a load
    ls[0] = 1'b1;
    tick();
    ls[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lv[0] = 1'b1;
      ldat[0] = 8'($urandom);
      tick();
    end
    lv[0] = 1'b0;
    #2 nreset = 1'b0;
    #1;
    check("midload_rst_ready", {31'b0, o_ready[0]}, 32'd0);
    tick();
    nreset = 1'b1;
    nbytes[0] = 0;
    nbytes[1] = 0;
    fr[0] = 1'b1;
    addr[0] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_rvalid", {31'b0, o_rvalid[0]}, 32'd0);
      check("post_rst_loaded", {31'b0, o_loaded[0]}, 32'd0);
    end
    fr[0] = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
